ab_gen: RTL and testbench

//  Address-bus generator for the microcoded 65C02 core. Sits directly downstream of the

---
 rtl/ab_gen.sv | 186 ++++++++++++++++++
 tb/tb_ab_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ab_gen.sv
// ab_gen: address-bus generator for the microcoded 65C02 core.
// Each cycle it turns the sequencer's expanded ab_op word into the 16-bit
// address AB. The low byte comes from a 9-bit adder and the high byte from
// a small ALU that uses the adder's carry. The block keeps its own address
// history (ABR), program counter (PC) and operand latch (AHL), so indexing,
// branches, stack and vector accesses need no other state.
// The block has no sequencing state. Every ab_op value, reserved codes
// included, gives a defined address.

module ab_gen #(
    parameter logic [15:0] RESET_AB = 16'hFFFC,
    parameter logic [7:0]  VEC_HI   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [12:0] ab_op,
    input  logic [7:0]  DB,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    input  logic [7:0]  S,
    output logic [15:0] AB,
    output logic [15:0] PC
);

    // Low-byte source codes
    localparam logic [1:0] ABL_PC  = 2'b00;
    localparam logic [1:0] ABL_SEL = 2'b01;
    localparam logic [1:0] ABL_DB  = 2'b10;
    localparam logic [1:0] ABL_AHL = 2'b11;

    // High-byte source codes. 001 and 011 are reserved and read as zero.
    localparam logic [2:0] AHB_ZERO = 3'b000;
    localparam logic [2:0] AHB_ONE  = 3'b010;
    localparam logic [2:0] AHB_ABR  = 3'b100;
    localparam logic [2:0] AHB_ABRD = 3'b101;
    localparam logic [2:0] AHB_PC   = 3'b110;
    localparam logic [2:0] AHB_DB   = 3'b111;

    // Index-operand codes. 11x is reserved and reads as zero.
    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_X    = 3'b001;
    localparam logic [2:0] SEL_Y    = 3'b010;
    localparam logic [2:0] SEL_S    = 3'b011;
    localparam logic [2:0] SEL_ABRL = 3'b100;
    localparam logic [2:0] SEL_PCL  = 3'b101;

    // ab_op fields
    logic       op_i;
    logic       op_p;
    logic       op_h;
    logic       op_f;
    logic [2:0] op_ahb;
    logic [2:0] op_sel;
    logic [1:0] op_abl;
    logic       op_ci;

    // State registers
    logic [15:0] abr_reg, abr_next;
    logic [15:0] pc_reg,  pc_next;
    logic [7:0]  ahl_reg, ahl_next;

    // Datapath intermediates
    logic [7:0]  sel_operand;
    logic [7:0]  lo_base;
    logic [8:0]  lo_sum;
    logic        lo_carry;
    logic [7:0]  hi_byte;
    logic [15:0] ab_live;
    logic [15:0] ab_plus_one;

    assign op_i   = ab_op[12];
    assign op_p   = ab_op[11];
    assign op_h   = ab_op[10];
    assign op_f   = ab_op[9];
    assign op_ahb = ab_op[8:6];
    assign op_sel = ab_op[5:3];
    assign op_abl = ab_op[2:1];
    assign op_ci  = ab_op[0];

    // Select the index or offset operand for the low-byte adder
    always_comb begin
        sel_operand = 8'h00;
        case (op_sel)
            SEL_ZERO: sel_operand = 8'h00;
            SEL_X:    sel_operand = X;
            SEL_Y:    sel_operand = Y;
            SEL_S:    sel_operand = S;
            SEL_ABRL: sel_operand = abr_reg[7:0];
            SEL_PCL:  sel_operand = pc_reg[7:0];
            default:  sel_operand = 8'h00;
        endcase
    end

    // Low-byte adder. PC-low passes straight through with no carry.
    always_comb begin
        lo_base = 8'h00;
        lo_sum  = 9'h000;
        case (op_abl)
            ABL_PC: begin
                lo_base = pc_reg[7:0];
                lo_sum  = {1'b0, pc_reg[7:0]};
            end
            ABL_SEL: begin
                lo_base = 8'h00;
                lo_sum  = {1'b0, lo_base} + {1'b0, sel_operand} + {8'h00, op_ci};
            end
            ABL_DB: begin
                lo_base = DB;
                lo_sum  = {1'b0, lo_base} + {1'b0, sel_operand} + {8'h00, op_ci};
            end
            ABL_AHL: begin
                lo_base = ahl_reg;
                lo_sum  = {1'b0, lo_base} + {1'b0, sel_operand} + {8'h00, op_ci};
            end
            default: begin
                lo_base = 8'h00;
                lo_sum  = 9'h000;
            end
        endcase
    end

    assign lo_carry = lo_sum[8];

    // High-byte ALU. Codes 000 and 010 ignore the carry, so zero-page and
    // stack accesses wrap within their page. Code 101 with the carry gives
    // the borrow that a backward (negative) branch needs.
    always_comb begin
        hi_byte = 8'h00;
        case (op_ahb)
            AHB_ZERO: hi_byte = 8'h00;
            AHB_ONE:  hi_byte = 8'h01;
            AHB_ABR:  hi_byte = abr_reg[15:8] + {7'h00, lo_carry};
            AHB_ABRD: hi_byte = abr_reg[15:8] - 8'h01 + {7'h00, lo_carry};
            AHB_PC:   hi_byte = pc_reg[15:8];
            AHB_DB:   hi_byte = DB + {7'h00, lo_carry};
            default:  hi_byte = 8'h00;
        endcase
        if (op_f) begin
            hi_byte = VEC_HI;
        end
    end

    assign ab_live     = {hi_byte, lo_sum[7:0]};
    assign ab_plus_one = ab_live + 16'h0001;

    // Output address: reset vector while in reset, frozen during a stall,
    // otherwise the live address with no register stage
    always_comb begin
        AB = ab_live;
        if (reset) begin
            AB = RESET_AB;
        end else if (!rdy) begin
            AB = abr_reg;
        end
    end

    // Next-state values used on cycles that advance
    always_comb begin
        abr_next = ab_live;
        pc_next  = pc_reg;
        ahl_next = ahl_reg;
        if (op_p) begin
            pc_next = op_i ? ab_plus_one : ab_live;
        end
        if (op_h) begin
            ahl_next = DB;
        end
    end

    // State update. Reset takes priority over rdy. A stall holds every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            abr_reg <= RESET_AB;
            pc_reg  <= RESET_AB;
            ahl_reg <= 8'h00;
        end else if (rdy) begin
            abr_reg <= abr_next;
            pc_reg  <= pc_next;
            ahl_reg <= ahl_next;
        end
    end

    assign PC = pc_reg;

endmodule

// File: tb/tb_ab_gen.sv
// Testbench for ab_gen. Directed vectors with hand-computed addresses.
// Stimulus pushes expected {AB, PC} into a queue. A monitor on the falling
// edge pops each entry and compares it with the DUT outputs.

module tb_ab_gen;

    logic        clk;
    logic        reset;
    logic        rdy;
    logic [12:0] ab_op;
    logic [7:0]  db;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  s;
    logic [15:0] ab;
    logic [15:0] pc;

    typedef struct {
        logic [15:0] ab;
        logic [15:0] pc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    ab_gen #(
        .RESET_AB(16'hFFFC),
        .VEC_HI  (8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rdy  (rdy),
        .ab_op(ab_op),
        .DB   (db),
        .X    (x),
        .Y    (y),
        .S    (s),
        .AB   (ab),
        .PC   (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an ab_op word: {I,P,H,F,AHB,SEL,ABL,CI}
    function automatic logic [12:0] mk(input logic i, input logic p, input logic h,
                                       input logic f, input logic [2:0] ahb,
                                       input logic [2:0] sel, input logic [1:0] abl,
                                       input logic ci);
        return {i, p, h, f, ahb, sel, abl, ci};
    endfunction

    // Drive one cycle of inputs after the rising edge and queue its expectation
    task automatic step(input logic rst, input logic rd, input logic [12:0] op,
                        input logic [7:0] d, input logic [15:0] eab,
                        input logic [15:0] epc, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        rdy   = rd;
        ab_op = op;
        db    = d;
        e.ab   = eab;
        e.pc   = epc;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the queued expectation with the outputs at mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (ab === e.ab) begin
                n_pass++;
            end else begin
                $display("FAIL %s AB: got %h expected %h", e.name, ab, e.ab);
            end
            n_total++;
            if (pc === e.pc) begin
                n_pass++;
            end else begin
                $display("FAIL %s PC: got %h expected %h", e.name, pc, e.pc);
            end
            $display("txn %-14s AB=%h PC=%h (exp %h %h)", e.name, ab, pc, e.ab, e.pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        rdy   = 1'b0;
        ab_op = 13'h0000;
        db    = 8'h00;
        x     = 8'h20;
        y     = 8'h01;
        s     = 8'h00;

        // 1. Reset with rdy=0 and a reset that overrides an active ab_op
        step(1, 0, mk(0,0,0,0,3'b000,3'b000,2'b00,0), 8'h00, 16'hFFFC, 16'hFFFC, "reset");
        step(1, 1, mk(1,1,1,1,3'b111,3'b001,2'b10,1), 8'h12, 16'hFFFC, 16'hFFFC, "reset_rdy");
        step(0, 0, mk(1,1,1,0,3'b110,3'b000,2'b00,0), 8'h55, 16'hFFFC, 16'hFFFC, "post_rst_hold");
        step(0, 0, mk(1,1,0,0,3'b111,3'b000,2'b10,0), 8'h55, 16'hFFFC, 16'hFFFC, "post_rst_hold2");

        // Load PC=1234: latch 34 into AHL, then AB={DB,AHL} with P=1,I=0
        step(0, 1, mk(0,0,1,0,3'b000,3'b000,2'b00,0), 8'h34, 16'h00FC, 16'hFFFC, "latch_34");
        step(0, 1, mk(0,1,0,0,3'b111,3'b000,2'b11,0), 8'h12, 16'h1234, 16'hFFFC, "load_pc");

        // 2. Fetch, then ABR-relative carry into the high byte
        step(0, 1, mk(1,1,0,0,3'b110,3'b000,2'b00,0), 8'h00, 16'h1234, 16'h1234, "fetch");
        step(0, 1, mk(0,0,0,0,3'b100,3'b000,2'b10,0), 8'hFF, 16'h12FF, 16'h1235, "set_abr_12ff");
        step(0, 1, mk(0,0,0,0,3'b100,3'b100,2'b01,1), 8'h00, 16'h1300, 16'h1235, "abr_inc_carry");

        // 3. Zero-page wrap: F0+20 keeps high byte at 00
        step(0, 1, mk(0,0,0,0,3'b000,3'b001,2'b10,0), 8'hF0, 16'h0010, 16'h1235, "zp_wrap");

        // 4. Absolute indexed: latch FF, then 20:FF + Y(01) = 2100
        step(0, 1, mk(0,0,1,0,3'b110,3'b000,2'b00,0), 8'hFF, 16'h1235, 16'h1235, "latch_ff");
        step(0, 1, mk(0,0,0,0,3'b111,3'b010,2'b11,0), 8'h20, 16'h2100, 16'h1235, "abs_idx");

        // 5. Branches relative to ABR=1000
        step(0, 1, mk(0,0,0,0,3'b111,3'b000,2'b01,0), 8'h10, 16'h1000, 16'h1235, "set_abr_1000");
        step(0, 1, mk(0,0,0,0,3'b101,3'b100,2'b10,1), 8'hFE, 16'h0FFF, 16'h1235, "branch_back");
        step(0, 1, mk(0,0,0,0,3'b111,3'b000,2'b01,0), 8'h10, 16'h1000, 16'h1235, "set_abr_1000b");
        step(0, 1, mk(0,0,0,0,3'b100,3'b100,2'b10,1), 8'h7F, 16'h1080, 16'h1235, "branch_fwd");
        // Backward branch with a low-byte carry: FE+80+1 = 17F, high 10-1+1 = 10
        step(0, 1, mk(0,0,0,0,3'b101,3'b100,2'b10,1), 8'hFE, 16'h107F, 16'h1235, "branch_back_co");

        // 6. Stack page (also latch A5), vector, then a stall
        step(0, 1, mk(0,0,1,0,3'b010,3'b011,2'b01,0), 8'hA5, 16'h0100, 16'h1235, "stack");
        step(0, 1, mk(0,0,0,1,3'b000,3'b000,2'b01,0), 8'h00, 16'hFF00, 16'h1235, "vector");
        step(0, 0, mk(1,1,1,0,3'b111,3'b001,2'b10,1), 8'h3C, 16'hFF00, 16'h1235, "stall1");
        step(0, 0, mk(1,1,1,1,3'b110,3'b000,2'b00,0), 8'h3C, 16'hFF00, 16'h1235, "stall2");
        step(0, 1, mk(0,0,0,0,3'b000,3'b000,2'b11,0), 8'h00, 16'h00A5, 16'h1235, "ahl_held");

        // PC increment wraps FFFF -> 0000
        step(0, 1, mk(1,1,0,0,3'b111,3'b000,2'b10,0), 8'hFF, 16'hFFFF, 16'h1235, "pc_to_ffff");
        step(0, 1, mk(0,0,0,0,3'b000,3'b000,2'b00,0), 8'h00, 16'h0000, 16'h0000, "pc_wrap");

        // Reserved codes read as zero: SEL 111, AHB 001 and 011
        step(0, 1, mk(0,0,0,0,3'b001,3'b111,2'b01,1), 8'h00, 16'h0001, 16'h0000, "rsvd_sel_ahb");
        step(0, 1, mk(0,0,0,0,3'b011,3'b110,2'b10,0), 8'h42, 16'h0042, 16'h0000, "rsvd_ahb011");

        // Reset mid-run: AB switches at once, PC reloads at the edge
        step(1, 0, mk(0,0,0,0,3'b000,3'b000,2'b00,0), 8'h00, 16'hFFFC, 16'h0000, "reset_again");
        step(0, 0, mk(0,0,0,0,3'b000,3'b000,2'b00,0), 8'h00, 16'hFFFC, 16'hFFFC, "after_reset");

        // Let the monitor drain. An undrained queue counts as a failure.
        repeat (3) @(posedge clk);
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
